// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit in front of a word-only data memory.
// Handles byte/halfword lane selection, sign/zero extension, alignment and
// funct3 checks, and turns SB/SH into a read-modify-write of the full word.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state, next_state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept = (state == IDLE) && req_valid;

  // Classify the incoming request: unknown funct3 / unsigned stores, then alignment
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_B:         req_illegal = 1'b0;
      F3_H:         req_misaligned = req_addr[0];
      F3_W:         req_misaligned = (req_addr[1:0] != 2'b00);
      F3_BU:        req_illegal = req_we;
      F3_HU: begin
        req_illegal    = req_we;
        req_misaligned = req_addr[0];
      end
      default:      req_illegal = 1'b1;
    endcase
  end

  // Next-state logic; errors take priority and go straight to the response
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misaligned) next_state = RESP;
          else if (!req_we)                  next_state = LOAD;
          else if (req_funct3 == F3_W)       next_state = WRITE;
          else                               next_state = RMW_RD;
        end
      end
      LOAD:    next_state = RESP;
      RMW_RD:  next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Little-endian lane extraction and sign/zero extension of the read word
  always_comb begin
    case (addr_q[1:0])
      2'b00:   load_byte = mem_rd[7:0];
      2'b01:   load_byte = mem_rd[15:8];
      2'b10:   load_byte = mem_rd[23:16];
      default: load_byte = mem_rd[31:24];
    endcase
    load_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'h0, load_byte};
      F3_HU:   load_data = {16'h0, load_half};
      default: load_data = mem_rd;
    endcase
  end

  // Build the word to write: replace only the addressed lane of the captured word
  always_comb begin
    merged_word = merge_q;
    case (funct3_q)
      F3_B: begin
        case (addr_q[1:0])
          2'b00:   merged_word[7:0]   = wdata_q[7:0];
          2'b01:   merged_word[15:8]  = wdata_q[7:0];
          2'b10:   merged_word[23:16] = wdata_q[7:0];
          default: merged_word[31:24] = wdata_q[7:0];
        endcase
      end
      F3_H: begin
        if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
        else           merged_word[15:0]  = wdata_q[15:0];
      end
      default: merged_word = wdata_q;
    endcase
  end

  // State register; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Request latch, load result, RMW capture and error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 2'b00;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= 32'h0;
        if (req_illegal)         err_q <= 2'b10;
        else if (req_misaligned) err_q <= 2'b01;
        else                     err_q <= 2'b00;
      end
      if (state == LOAD)   rdata_q <= load_data;
      if (state == RMW_RD) merge_q <= mem_rd;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_we     = (state == WRITE) && we_q;
  assign mem_wd     = (state == WRITE) ? merged_word : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed test of lsu_ctrl against a small word memory model.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:15];
  logic        preloadEn;
  logic [3:0]  preloadIdx;
  logic [31:0] preloadData;

  int checks;
  int failures;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory with combinational read and clocked write, plus a preload port
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) begin
    if (preloadEn)   mem[preloadIdx] <= preloadData;
    else if (mem_we) mem[mem_a[5:2]] <= mem_wd;
  end

  // Count a comparison and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic preloadWord(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadIdx  = idx;
    preloadData = data;
    @(posedge clk);
    #1 preloadEn = 1'b0;
  endtask

  // Issue one request and follow it to its response; latency counted in cycles after acceptance
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                               output int lat, output logic [31:0] rdata,
                               output logic [1:0] err, output int wePulses,
                               output logic [31:0] lastWd);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    if (!hold) #1 req_valid = 1'b0;
    lat      = -1;
    wePulses = 0;
    lastWd   = 32'h0;
    rdata    = 32'h0;
    err      = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wePulses++;
        lastWd = mem_wd;
      end
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  // Run a request and check latency, data, error and number of memory writes
  task automatic runCase(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int expLat, input logic [31:0] expData,
                         input logic [1:0] expErr, input int expWe);
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          pulses;
    logic [31:0] lastWd;
    applyStimulus(tag, we, f3, addr, wd, 1'b0, lat, rdata, err, pulses, lastWd);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_rdata"}, rdata, expData);
    checkOutput({tag, "_err"}, {30'h0, err}, {30'h0, expErr});
    checkOutput({tag, "_wecount"}, pulses, expWe);
  endtask

  initial begin
    int          lat;
    int          pulses;
    int          extra;
    logic [31:0] rdata;
    logic [31:0] lastWd;
    logic [1:0]  err;
    bit          sawWe;

    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'b000;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    preloadEn   = 1'b0;
    preloadIdx  = 4'h0;
    preloadData = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_err", {30'h0, resp_err}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mem_a", mem_a, 32'h0);
    checkOutput("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    preloadWord(4'd4, 32'h8899AABB);
    preloadWord(4'd2, 32'h11223344);
    preloadWord(4'd5, 32'h00000000);

    // Loads
    runCase("lw",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h8899AABB, 2'b00, 0);
    runCase("lb",  1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFFFFAA, 2'b00, 0);
    runCase("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h00000088, 2'b00, 0);
    runCase("lh",  1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF8899, 2'b00, 0);
    runCase("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 2, 32'h0000AABB, 2'b00, 0);
    runCase("lb0", 1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFFFFBB, 2'b00, 0);

    // Sub-word stores via read-modify-write
    applyStimulus("sb", 1'b1, 3'b000, 32'h0A, 32'hDEADBEEF, 1'b0, lat, rdata, err, pulses, lastWd);
    checkOutput("sb_lat", lat, 3);
    checkOutput("sb_wecount", pulses, 1);
    checkOutput("sb_wd", lastWd, 32'h11EF3344);
    checkOutput("sb_rdata", rdata, 32'h0);
    checkOutput("sb_err", {30'h0, err}, 32'h0);
    checkOutput("sb_mem", mem[2], 32'h11EF3344);

    applyStimulus("sh", 1'b1, 3'b001, 32'h08, 32'h0000CAFE, 1'b0, lat, rdata, err, pulses, lastWd);
    checkOutput("sh_lat", lat, 3);
    checkOutput("sh_wecount", pulses, 1);
    checkOutput("sh_mem", mem[2], 32'h11EFCAFE);

    applyStimulus("sw", 1'b1, 3'b010, 32'h14, 32'h12345678, 1'b0, lat, rdata, err, pulses, lastWd);
    checkOutput("sw_lat", lat, 2);
    checkOutput("sw_wecount", pulses, 1);
    checkOutput("sw_mem", mem[5], 32'h12345678);
    checkOutput("sw_neighbour", mem[4], 32'h8899AABB);

    // Misaligned accesses
    runCase("mis_lw",  1'b0, 3'b010, 32'h0D, 32'h0, 1, 32'h0, 2'b01, 0);
    runCase("mis_sh",  1'b1, 3'b001, 32'h0B, 32'hFFFF, 1, 32'h0, 2'b01, 0);
    runCase("mis_lhu", 1'b0, 3'b101, 32'h03, 32'h0, 1, 32'h0, 2'b01, 0);

    // Illegal funct3, including priority over misalignment
    runCase("ill_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 2'b10, 0);
    runCase("ill_sbu", 1'b1, 3'b100, 32'h08, 32'hFF, 1, 32'h0, 2'b10, 0);
    runCase("ill_prio", 1'b0, 3'b110, 32'h0B, 32'h0, 1, 32'h0, 2'b10, 0);
    checkOutput("ill_mem", mem[2], 32'h11EFCAFE);

    // Valid held through the busy and response cycles: exactly one response
    applyStimulus("hold", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, lat, rdata, err, pulses, lastWd);
    checkOutput("hold_lat", lat, 2);
    checkOutput("hold_rdata", rdata, 32'h8899AABB);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    checkOutput("hold_extra_resp", extra, 0);
    checkOutput("hold_ready", {31'h0, req_ready}, 32'h1);

    // Reset while in WRITE of an SB: write dropped, no response
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h09;
    req_wdata  = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    sawWe = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_we) begin
        sawWe = 1'b1;
        break;
      end
    end
    checkOutput("rstw_reached_write", {31'h0, sawWe}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_we_drop", {31'h0, mem_we}, 32'h0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    checkOutput("rstw_no_resp", extra, 0);
    checkOutput("rstw_mem", mem[2], 32'h11EFCAFE);
    checkOutput("rstw_ready", {31'h0, req_ready}, 32'h1);

    // Unit is usable after the abandoned request
    runCase("post_lhu", 1'b0, 3'b101, 32'h0A, 32'h0, 2, 32'h000011EF, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly upstream of `data_memory`. It accepts one load or store request at a time from the execute/memory stage and handles the sub-word accesses of RV32I: byte/halfword lane selection, sign/zero extension, and alignment and funct3 checks. Because the memory only supports whole-word writes, SB/SH are performed as a read-modify-write. It drives the memory's `WE/A/WD` ports and consumes `RD`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, can accept request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; bits [7:0] are used for B, [15:0] for H
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result, extended; 0 for stores and errors
- `resp_err`  out  2  00 ok, 01 misaligned, 10 illegal funct3
- `mem_we`  out  1  to `data_memory` WE
- `mem_a`  out  32  to `data_memory` A, always word-aligned
- `mem_wd`  out  32  to `data_memory` WD
- `mem_rd`  in  32  from `data_memory` RD (combinational read)

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `we`, `funct3`, `addr`, `wdata`, then check in priority order:
    - illegal funct3 (011, 110, 111, or 100/101 with `we`=1) -> RESP with err 10;
    - misaligned (H/HU with addr[0]=1; W with addr[1:0]≠00) -> RESP with err 01;
    - load -> LOAD;
    - SW -> WRITE;
    - SB/SH -> RMW_RD.
- **LOAD**
  - Extract from `mem_rd`, little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Register the result into `resp_rdata`, then go to RESP.
- **RMW_RD**
  - Capture `mem_rd` into a merge register, then go to WRITE.
- **WRITE**
  - `mem_we`=1 and `mem_wd` = merged word.
  - SW: `mem_wd` = `wdata`.
  - SB: only the addressed byte is replaced by `wdata[7:0]`.
  - SH: only the addressed halfword is replaced by `wdata[15:0]`.
  - Next state: RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `resp_rdata` and `resp_err` are valid only while `resp_valid`=1.
- `mem_a` = {addr_q[31:2], 2'b00} in every state. `mem_we`=1 only in WRITE.
- Errored requests never assert `mem_we`.
- `resp_rdata` is forced to 0 for stores and errors.
- There is no backpressure on the response. The requester must hold off while `req_ready`=0; a `req_valid` seen outside IDLE is ignored.

## Timing
- Reset (async assert, synchronous release): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=00, `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Reset asserted mid-operation (including in WRITE) drops `mem_we` immediately and abandons the request. No response is generated.
- Latency, with the request accepted at edge T:

| Request | `resp_valid` high in cycle | Notes |
|---|---|---|
| Error | T+1 | |
| Load | T+2 | |
| SW | T+2 | write at edge ending the T+1 cycle |
| SB/SH | T+3 | read in T+1, write at end of T+2 |

- `req_ready` returns to 1 in the cycle after RESP. Back-to-back throughput is therefore one request per 3 cycles for load/SW and 4 cycles for SB/SH.
- A request presented in the same cycle that RESP ends is not accepted; it is accepted on the following IDLE cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RMW (WRITE state) -> `mem_we` falls within the same cycle, no `resp_valid`, and the memory word is unchanged.
- **LW:** mem[4]=0x8899AABB, LW addr 0x10 -> `resp_rdata`=0x8899AABB, err 00, `resp_valid` 2 cycles after acceptance.
- **Sub-word loads:** mem[4]=0x8899AABB.
  - LB 0x11 -> 0xFFFFFFAA.
  - LBU 0x13 -> 0x00000088.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
- **SB:** mem[2]=0x11223344, SB addr 0x0A, wdata 0xDEADBEEF -> a single `mem_we` pulse with `mem_wd`=0x11EF3344, `resp_valid` 3 cycles after acceptance.
  - A following SH addr 0x08, wdata 0x0000CAFE -> mem[2]=0x11EFCAFE.
- **Misaligned:** LW 0x0D, SH 0x0B, LHU 0x03 -> each gives err 01, `resp_valid` at T+1, `mem_we` never asserted, `resp_rdata`=0.
- **Illegal funct3:** funct3 011, and SBU (store with funct3 100) -> err 10, no memory write. A `req_valid` held high while busy is not double-accepted: exactly one response per handshake.
